// File: rtl/uart_word_demux.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_demux
// Description : UART receive-side word distributor. Deserialises 8N1 frames
//               from an asynchronous serial line and packs LENGTH/8 bytes,
//               little-endian, into one word. It then writes each completed
//               word into one of four registered destinations (A/B/C/D),
//               chosen by sel.
//
// Parameters  : LENGTH   - output word width. Must be a multiple of 8 and at
//                          least 8.
//               BAUD_DIV - clk cycles per UART bit. Must be at least 4.
//
// Ports       : clk        in   system clock, rising edge
//               rst        in   asynchronous active-low reset
//               enable     in   gates the start of a new frame only
//               rx         in   UART serial line (idle high, async to clk)
//               sel[1:0]   in   destination of the next completed word
//               A,B,C,D    out  destination registers 0..3 (LENGTH bits)
//               word_valid out  one-cycle pulse when a destination is written
//               frame_err  out  one-cycle pulse on a bad stop bit
//               busy       out  high while the receiver FSM is not idle
//
// Options     : UART_WORD_TIMEOUT_EN - when defined, a partial word is
//               discarded after 32*BAUD_DIV idle-line cycles without a start
//               bit. When undefined, a partial word waits indefinitely.
//
// Revision    : 1.0 - initial release
// ============================================================================

module uart_word_demux #(
    parameter int LENGTH   = 32,
    parameter int BAUD_DIV = 5208
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx,
    input  logic [1:0]        sel,
    output logic [LENGTH-1:0] A,
    output logic [LENGTH-1:0] B,
    output logic [LENGTH-1:0] C,
    output logic [LENGTH-1:0] D,
    output logic              word_valid,
    output logic              frame_err,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_NBYTES = LENGTH / 8;
    localparam int c_BCW    = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam int c_BW     = $clog2(BAUD_DIV);

    localparam logic [c_BW-1:0]  c_HALF = c_BW'(BAUD_DIV / 2 - 1);
    localparam logic [c_BW-1:0]  c_FULL = c_BW'(BAUD_DIV - 1);
    localparam logic [c_BCW-1:0] c_LAST = c_BCW'(c_NBYTES - 1);

    // FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              rx_m_q;      // first synchroniser stage
    logic              rx_s_q;      // synchronised rx
    logic              rx_p_q;      // previous-cycle copy of rx_s_q

    logic [1:0]        state_q,   state_d;
    logic [c_BW-1:0]   baud_q,    baud_d;
    logic [2:0]        bit_q,     bit_d;
    logic [c_BCW-1:0]  byte_q,    byte_d;
    logic [7:0]        shift_q,   shift_d;
    logic [LENGTH-1:0] word_q,    word_d;
    logic [1:0]        sel_q,     sel_d;
    logic              wr_pend_q, wr_pend_d;

    logic [LENGTH-1:0] a_q, a_d;
    logic [LENGTH-1:0] b_q, b_d;
    logic [LENGTH-1:0] c_q, c_d;
    logic [LENGTH-1:0] d_q, d_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q,  frame_err_d;

    // A falling edge on the synchronised line while idle and enabled is a
    // start-bit candidate. A line held low produces no further edges, so a
    // break yields exactly one framing error.
    logic start_det;
    assign start_det = (state_q == c_IDLE) && enable && rx_p_q && !rx_s_q;

`ifdef UART_WORD_TIMEOUT_EN
    localparam int                c_TOW     = $clog2(32 * BAUD_DIV);
    localparam logic [c_TOW-1:0]  c_TO_LAST = c_TOW'(32 * BAUD_DIV - 1);

    logic [c_TOW-1:0] idle_q, idle_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        shift_d      = shift_q;
        word_d       = word_q;
        sel_d        = sel_q;
        wr_pend_d    = 1'b0;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // The word (final byte already merged) and sel were captured at
        // the stop-bit sample edge. Commit them one edge later, with the
        // valid pulse in the same cycle as the new output value.
        if (wr_pend_q) begin
            word_valid_d = 1'b1;
            case (sel_q)
                2'd0:    a_d = word_q;
                2'd1:    b_d = word_q;
                2'd2:    c_d = word_q;
                default: d_d = word_q;
            endcase
        end

        case (state_q)
            c_IDLE: begin
                baud_d = '0;
                if (start_det) begin
                    state_d = c_START;
                end
            end

            c_START: begin
                if (baud_q == c_HALF) begin
                    baud_d = '0;
                    bit_d  = 3'd0;
                    // A line that is high again at mid-start was a glitch.
                    // Drop it silently.
                    state_d = rx_s_q ? c_IDLE : c_DATA;
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end

            c_DATA: begin
                if (baud_q == c_FULL) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};   // LSB first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end

            c_STOP: begin
                if (baud_q == c_FULL) begin
                    baud_d = '0;
                    // Leave half a bit early so a back-to-back start edge
                    // is seen from IDLE.
                    state_d = c_IDLE;
                    if (rx_s_q) begin
                        word_d[{byte_q, 3'b000} +: 8] = shift_q;
                        if (byte_q == c_LAST) begin
                            byte_d    = '0;
                            sel_d     = sel;
                            wr_pend_d = 1'b1;
                        end else begin
                            byte_d = byte_q + c_BCW'(1);
                        end
                    end else begin
                        // Bad stop bit: drop this byte and the partial word.
                        frame_err_d = 1'b1;
                        byte_d      = '0;
                    end
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end

            default: begin
                state_d = c_IDLE;
                baud_d  = '0;
            end
        endcase

`ifdef UART_WORD_TIMEOUT_EN
        // Idle-line watchdog for partially packed words. It runs only
        // while idle with bytes pending. It restarts on every start-bit
        // detection. On expiry it flushes the partial word quietly.
        idle_d = '0;
        if ((state_q == c_IDLE) && (byte_q != '0) && !start_det) begin
            if (idle_q == c_TO_LAST) begin
                byte_d = '0;
            end else begin
                idle_d = idle_q + c_TOW'(1);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_p_q       <= 1'b1;
            state_q      <= c_IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            byte_q       <= '0;
            shift_q      <= 8'd0;
            word_q       <= '0;
            sel_q        <= 2'd0;
            wr_pend_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_m_q       <= rx;
            rx_s_q       <= rx_m_q;
            rx_p_q       <= rx_s_q;
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            sel_q        <= sel_d;
            wr_pend_q    <= wr_pend_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef UART_WORD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A          = a_q;
    assign B          = b_q;
    assign C          = c_q;
    assign D          = d_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_word_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_demux
// Description : Self-checking bench for uart_word_demux (LENGTH=32,
//               BAUD_DIV=16). Directed frames cover the following cases:
//                 - reset state
//                 - word packing and latency
//                 - sel sampling
//                 - framing errors
//                 - glitches
//                 - the enable gate
//                 - line breaks
//                 - the idle timeout option
//                 - asynchronous reset
//               A randomised frame sequence then follows. All frames are
//               checked against a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_word_demux;

    localparam int LEN = 32;
    localparam int BD  = 16;
    localparam int NB  = LEN / 8;

    logic           clk    = 1'b0;
    logic           rst    = 1'b0;
    logic           enable = 1'b1;
    logic           rx     = 1'b1;
    logic [1:0]     sel    = 2'd0;
    logic [LEN-1:0] A, B, C, D;
    logic           word_valid, frame_err, busy;

    uart_word_demux #(
        .LENGTH   (LEN),
        .BAUD_DIV (BD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx         (rx),
        .sel        (sel),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and output pulse monitors
    int cyc      = 0;
    int wv_cnt   = 0;
    int fe_cnt   = 0;
    int busy_cnt = 0;
    int wv_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (word_valid) begin
                wv_cnt = wv_cnt + 1;
                wv_cyc = cyc;
            end
            if (frame_err) fe_cnt   = fe_cnt + 1;
            if (busy)      busy_cnt = busy_cnt + 1;
        end
    end

    // Checking
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of accepted bytes for the word being built
    logic [7:0]     mq[$];
    logic [LEN-1:0] exp_reg[4];
    int             exp_wv = 0;
    int             exp_fe = 0;

    task automatic model_byte(input logic [7:0] b, input logic ok, input logic [1:0] s);
        logic [LEN-1:0] w;
        if (!ok) begin
            exp_fe++;
            mq.delete();
        end else begin
            mq.push_back(b);
            if (mq.size() == NB) begin
                w = '0;
                for (int k = 0; k < NB; k++) w = w | (LEN'(mq[k]) << (8 * k));
                exp_reg[s] = w;
                exp_wv++;
                mq.delete();
            end
        end
    endtask

    task automatic model_idle(input int cycles);
`ifdef UART_WORD_TIMEOUT_EN
        if (cycles >= 32 * BD) mq.delete();
`else
        if (cycles < 0) mq.delete();
`endif
    endtask

    // Stimulus. Every rx change happens 1 time unit after a rising edge.
    int t0 = 0;

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic frame_bits(input logic [7:0] b, input logic stop);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok);
        frame_bits(b, ok);
        model_byte(b, ok, sel);
        if (!ok) drive_bit(1'b1);   // restore idle so the next start edge exists
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        int         gap;
        int         snap;
        for (int i = 0; i < 4; i++) exp_reg[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_C", C, 0);
        check("rst_D", D, 0);
        check("rst_busy", busy, 0);
        check("rst_wv", word_valid, 0);
        check("rst_fe", frame_err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic packing into B, including latency
        sel = 2'd1;
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        settle();
        check("t2_B", B, 32'h12345678);
        check("t2_A", A, 0);
        check("t2_C", C, 0);
        check("t2_D", D, 0);
        check("t2_wv_cnt", wv_cnt, 1);
        check("t2_latency", wv_cyc, t0 + 3 + BD / 2 + 9 * BD + 1);

        // sel is taken at the final byte's stop sample
        sel = 2'd2;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        sel = 2'd3;
        send_byte(8'h04, 1'b1);
        settle();
        check("t3_D", D, 32'h04030201);
        check("t3_C", C, 0);
        check("t3_B", B, 32'h12345678);
        check("t3_wv_cnt", wv_cnt, 2);

        // A bad stop bit drops the byte
        sel = 2'd0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        settle();
        check("t4_fe_cnt", fe_cnt, 1);
        check("t4_A", A, 32'h44332211);
        check("t4_wv_cnt", wv_cnt, 3);

        // Start glitch and disabled frame, both with a partial word held
        send_byte(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * BD) @(posedge clk);
        #1;
        check("t5_glitch_fe", fe_cnt, 1);
        enable = 1'b0;
        snap   = busy_cnt;
        frame_bits(8'hEE, 1'b1);
        drive_bit(1'b1);
        check("t5_dis_busy", busy_cnt, snap);
        check("t5_dis_A", A, 32'h44332211);
        check("t5_dis_wv", wv_cnt, 3);
        enable = 1'b1;
        sel    = 2'd2;
        send_byte(8'h6B, 1'b1);
        send_byte(8'h7C, 1'b1);
        send_byte(8'h8D, 1'b1);
        settle();
        check("t5_C", C, 32'h8D7C6B5A);

        // Line break: exactly one framing error, partial word discarded
        sel = 2'd3;
        send_byte(8'h99, 1'b1);
        rx = 1'b0;
        repeat (20 * BD) @(posedge clk);
        #1;
        exp_fe++;
        mq.delete();
        drive_bit(1'b1);
        check("t6_break_fe", fe_cnt, exp_fe);
        send_byte(8'hF1, 1'b1);
        send_byte(8'hF2, 1'b1);
        send_byte(8'hF3, 1'b1);
        send_byte(8'hF4, 1'b1);
        settle();
        check("t6_D", D, 32'hF4F3F2F1);

        // Idle timeout on a partial word
        sel = 2'd0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (600) @(posedge clk);
        #1;
        model_idle(600);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hAA, 1'b1);
        settle();
`ifdef UART_WORD_TIMEOUT_EN
        check("t7_A", A, 32'hAABBCCDD);
`else
        check("t7_A", A, 32'hCCDD0201);
`endif
        check("t7_A_model", A, exp_reg[0]);
        check("t7_wv_cnt", wv_cnt, exp_wv);

        // Randomised frames against the model
        for (int n = 0; n < 32; n++) begin
            rb  = 8'($urandom);
            sel = 2'($urandom_range(0, 3));
            send_byte(rb, ($urandom_range(0, 7) != 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        drive_bit(1'b1);
        settle();
        check("rnd_A", A, exp_reg[0]);
        check("rnd_B", B, exp_reg[1]);
        check("rnd_C", C, exp_reg[2]);
        check("rnd_D", D, exp_reg[3]);
        check("rnd_wv_cnt", wv_cnt, exp_wv);
        check("rnd_fe_cnt", fe_cnt, exp_fe);

        // Asynchronous reset in the middle of a frame
        rx = 1'b0;
        repeat (BD) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t9_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t9_A", A, 0);
        check("t9_B", B, 0);
        check("t9_C", C, 0);
        check("t9_D", D, 0);
        check("t9_busy", busy, 0);
        check("t9_wv", word_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t9_busy_after", busy, 0);
        check("t9_D_after", D, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
